// File: rtl/pim_job_scheduler.sv
// Dispatches the (tile, k-chunk) jobs of one blocked matmul onto a pool of PIM units.
// It issues round-robin, skips zero jobs, tracks outstanding work per tile and pulses completion.
module pim_job_scheduler #(
   parameter  int unsigned NUM_UNITS   = 4,
   parameter  int unsigned NUM_TILES   = 4,
   parameter  int unsigned NUM_KCHUNKS = 4,
   localparam int unsigned NJ = NUM_TILES * NUM_KCHUNKS,
   localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
   localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
   localparam int unsigned KW = (NUM_KCHUNKS > 1) ? $clog2(NUM_KCHUNKS) : 1,
   localparam int unsigned JW = $clog2(NJ + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NJ-1:0]        skip_mask,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic                 issue_valid,
   output logic [UW-1:0]        issue_unit,
   output logic [TW-1:0]        issue_tile,
   output logic [KW-1:0]        issue_kchunk,
   output logic [NUM_TILES-1:0] tile_done,
   output logic                 busy,
   output logic                 done,
   output logic [JW-1:0]        jobs_issued
);

   localparam int unsigned OW = $clog2(NUM_KCHUNKS + 1);
   localparam int unsigned CW = (NJ > 1) ? $clog2(NJ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [TW-1:0]        tile_q, tile_d;
   logic [KW-1:0]        kc_q, kc_d;
   logic [NJ-1:0]        skip_q, skip_d;
   logic [NUM_UNITS-1:0] ubusy_q, ubusy_d;
   logic [TW-1:0]        utile_q [NUM_UNITS];
   logic [TW-1:0]        utile_d [NUM_UNITS];
   logic [UW-1:0]        rr_q, rr_d;
   logic [OW-1:0]        outst_q [NUM_TILES];
   logic [OW-1:0]        outst_d [NUM_TILES];
   logic [NUM_TILES-1:0] eval_q, eval_d, fired_q, fired_d;
   logic [JW-1:0]        jobs_q, jobs_d;

   logic [CW-1:0]        cur_j;
   logic                 cur_skip, any_free, advance;
   logic [UW-1:0]        grant;

   assign cur_j    = CW'(32'(tile_q) * NUM_KCHUNKS + 32'(kc_q));
   assign cur_skip = skip_q[cur_j];

   // First free unit at or after rr_q; only registered busy bits count, so a
   // unit released this cycle is not a candidate until the next one.
   always_comb begin : arb
      int unsigned idx;
      any_free = 1'b0;
      grant    = '0;
      idx      = 0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
         if (!any_free && !ubusy_q[UW'(idx)]) begin
            any_free = 1'b1;
            grant    = UW'(idx);
         end
      end
   end

   assign issue_valid  = (state_q == S_DISPATCH) && !cur_skip && any_free;
   assign advance      = (state_q == S_DISPATCH) && (cur_skip || any_free);
   assign issue_unit   = issue_valid ? grant  : '0;
   assign issue_tile   = issue_valid ? tile_q : '0;
   assign issue_kchunk = issue_valid ? kc_q   : '0;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign jobs_issued  = jobs_q;

   always_comb begin
      tile_done = '0;
      for (int unsigned t = 0; t < NUM_TILES; t++)
         tile_done[t] = eval_q[t] && (outst_q[t] == '0) && !fired_q[t];
   end

   always_comb begin : next_state
      logic [OW-1:0] nxt;
      state_d = state_q;
      tile_d  = tile_q;
      kc_d    = kc_q;
      skip_d  = skip_q;
      rr_d    = rr_q;
      eval_d  = eval_q;
      fired_d = fired_q | tile_done;
      jobs_d  = jobs_q;
      ubusy_d = ubusy_q & ~unit_done;
      utile_d = utile_q;
      nxt     = '0;

      // Net per-tile count: +1 for an issue, -1 per completing unit holding it.
      for (int unsigned t = 0; t < NUM_TILES; t++) begin
         nxt = outst_q[t];
         if (issue_valid && (tile_q == TW'(t))) nxt = nxt + OW'(1);
         for (int unsigned u = 0; u < NUM_UNITS; u++)
            if (unit_done[u] && ubusy_q[u] && (utile_q[u] == TW'(t))) nxt = nxt - OW'(1);
         outst_d[t] = nxt;
      end

      if (issue_valid) begin
         ubusy_d[grant] = 1'b1;
         utile_d[grant] = tile_q;
         rr_d           = (grant == UW'(NUM_UNITS - 1)) ? '0 : grant + UW'(1);
         jobs_d         = jobs_q + JW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DISPATCH;
               tile_d  = '0;
               kc_d    = '0;
               skip_d  = skip_mask;
               eval_d  = '0;
               fired_d = '0;
               jobs_d  = '0;
               for (int unsigned t = 0; t < NUM_TILES; t++) outst_d[t] = '0;
            end
         end
         S_DISPATCH: begin
            if (advance) begin
               if (kc_q == KW'(NUM_KCHUNKS - 1)) begin
                  eval_d[tile_q] = 1'b1;
                  kc_d           = '0;
                  if (tile_q == TW'(NUM_TILES - 1)) state_d = S_DRAIN;
                  else                              tile_d  = tile_q + TW'(1);
               end else begin
                  kc_d = kc_q + KW'(1);
               end
            end
         end
         S_DRAIN: if (ubusy_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tile_q  <= '0;
         kc_q    <= '0;
         skip_q  <= '0;
         ubusy_q <= '0;
         utile_q <= '{default: '0};
         rr_q    <= '0;
         outst_q <= '{default: '0};
         eval_q  <= '0;
         fired_q <= '0;
         jobs_q  <= '0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         kc_q    <= kc_d;
         skip_q  <= skip_d;
         ubusy_q <= ubusy_d;
         utile_q <= utile_d;
         rr_q    <= rr_d;
         outst_q <= outst_d;
         eval_q  <= eval_d;
         fired_q <= fired_d;
         jobs_q  <= jobs_d;
      end
   end

endmodule

// File: tb/tb_pim_job_scheduler.sv
// Scoreboard bench for pim_job_scheduler: expected issues / tile_done / done events are
// queued per scenario with their cycle numbers and compared every cycle.
module tb_pim_job_scheduler;

   localparam int NU = 4;
   localparam int NT = 4;
   localparam int NK = 4;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] skip_mask;
   logic [3:0]  unit_done;
   logic        issue_valid;
   logic [1:0]  issue_unit, issue_tile, issue_kchunk;
   logic [3:0]  tile_done;
   logic        busy, done;
   logic [4:0]  jobs_issued;

   always #5 clk = ~clk;

   pim_job_scheduler #(.NUM_UNITS(NU), .NUM_TILES(NT), .NUM_KCHUNKS(NK)) dut (
      .clk(clk), .rst(rst), .start(start), .skip_mask(skip_mask), .unit_done(unit_done),
      .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_tile(issue_tile),
      .issue_kchunk(issue_kchunk), .tile_done(tile_done), .busy(busy), .done(done),
      .jobs_issued(jobs_issued)
   );

   typedef struct { int cyc; int t; int k; int u; } job_t;
   typedef struct { int cyc; logic [3:0] mask; } td_t;

   job_t exp_iss[$];
   td_t  exp_td[$];
   int   cyc, lat, done_cyc;
   int   done_at [NU];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic push_job(input int c, input int t, input int k, input int u);
      job_t j;
      j.cyc = c; j.t = t; j.k = k; j.u = u;
      exp_iss.push_back(j);
   endtask

   task automatic push_td(input int c, input logic [3:0] m);
      td_t d;
      d.cyc = c; d.mask = m;
      exp_td.push_back(d);
   endtask

   // Advance one cycle; the unit model answers each issue after lat cycles.
   task automatic step();
      logic [3:0] ud;
      @(posedge clk);
      #1;
      cyc++;
      ud = '0;
      for (int u = 0; u < NU; u++)
         if (done_at[u] == cyc) begin
            ud[u] = 1'b1;
            done_at[u] = -1;
         end
      if (issue_valid && lat > 0) done_at[issue_unit] = cyc + lat;
      unit_done = ud;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; unit_done = '0; skip_mask = '0;
      for (int u = 0; u < NU; u++) done_at[u] = -1;
      exp_iss.delete();
      exp_td.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== 7'd0)
         $display("FAIL reset_issue: got %b expected 0", {issue_valid, issue_unit, issue_tile, issue_kchunk});
      else n_pass++;
      n_total++;
      if ({tile_done, busy, done} !== 6'd0)
         $display("FAIL reset_status: got %b expected 0", {tile_done, busy, done});
      else n_pass++;
      n_total++;
      if (jobs_issued !== 5'd0) $display("FAIL reset_jobs: got %0d expected 0", jobs_issued);
      else n_pass++;
   endtask

   task automatic test_unit_fill();
      job_t j; logic [6:0] ev;
      do_reset();
      lat = 0; done_cyc = -1;
      for (int k = 0; k < 4; k++) push_job(k + 1, 0, k, k);
      start = 1'b1; cyc = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         start = 1'b0;
         ev = '0;
         if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            j = exp_iss.pop_front();
            ev = {1'b1, 2'(j.u), 2'(j.t), 2'(j.k)};
         end
         n_total++;
         if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== ev)
            $display("FAIL fill_issue c%0d: got %b expected %b", cyc, {issue_valid, issue_unit, issue_tile, issue_kchunk}, ev);
         else n_pass++;
      end
      n_total++;
      if ({busy, jobs_issued} !== {1'b1, 5'd4})
         $display("FAIL fill_state: got busy=%0b jobs=%0d expected busy=1 jobs=4", busy, jobs_issued);
      else n_pass++;
   endtask

   task automatic test_full_sweep();
      job_t j; td_t d; logic [6:0] ev; logic [3:0] em;
      do_reset();
      lat = 3; done_cyc = 21;
      for (int n = 0; n < 16; n++) push_job(n + 1, n / 4, n % 4, n % 4);
      for (int t = 0; t < 4; t++) push_td(8 + 4 * t, 4'(1 << t));
      start = 1'b1; cyc = 0;
      for (int c = 1; c <= 23; c++) begin
         step();
         start = 1'b0;
         ev = '0; em = '0;
         if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            j = exp_iss.pop_front();
            ev = {1'b1, 2'(j.u), 2'(j.t), 2'(j.k)};
         end
         if (exp_td.size() > 0 && exp_td[0].cyc == cyc) begin
            d = exp_td.pop_front();
            em = d.mask;
         end
         n_total++;
         if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== ev)
            $display("FAIL full_issue c%0d: got %b expected %b", cyc, {issue_valid, issue_unit, issue_tile, issue_kchunk}, ev);
         else n_pass++;
         n_total++;
         if (tile_done !== em) $display("FAIL full_tile_done c%0d: got %b expected %b", cyc, tile_done, em);
         else n_pass++;
         n_total++;
         if (done !== (cyc == done_cyc)) $display("FAIL full_done c%0d: got %b expected %b", cyc, done, cyc == done_cyc);
         else n_pass++;
      end
      n_total++;
      if ({busy, jobs_issued} !== {1'b0, 5'd16})
         $display("FAIL full_end: got busy=%0b jobs=%0d expected busy=0 jobs=16", busy, jobs_issued);
      else n_pass++;
   endtask

   task automatic test_all_skipped();
      td_t d; logic [3:0] em;
      do_reset();
      lat = 3; done_cyc = 18;
      for (int t = 0; t < 4; t++) push_td(5 + 4 * t, 4'(1 << t));
      skip_mask = '1; start = 1'b1; cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         start = 1'b0;
         em = '0;
         if (exp_td.size() > 0 && exp_td[0].cyc == cyc) begin
            d = exp_td.pop_front();
            em = d.mask;
         end
         n_total++;
         if (issue_valid !== 1'b0) $display("FAIL skip_issue c%0d: got %b expected 0", cyc, issue_valid);
         else n_pass++;
         n_total++;
         if (tile_done !== em) $display("FAIL skip_tile_done c%0d: got %b expected %b", cyc, tile_done, em);
         else n_pass++;
         n_total++;
         if (done !== (cyc == done_cyc)) $display("FAIL skip_done c%0d: got %b expected %b", cyc, done, cyc == done_cyc);
         else n_pass++;
      end
      n_total++;
      if ({busy, jobs_issued} !== 6'd0)
         $display("FAIL skip_end: got busy=%0b jobs=%0d expected busy=0 jobs=0", busy, jobs_issued);
      else n_pass++;
   endtask

   task automatic test_partial_skip();
      job_t j; td_t d; logic [6:0] ev; logic [3:0] em;
      do_reset();
      lat = 8; done_cyc = 32;
      for (int k = 0; k < 4; k++) push_job(1 + k, 0, k, k);
      for (int k = 0; k < 4; k++) push_job(10 + k, 2, k, k);
      for (int k = 0; k < 4; k++) push_job(19 + k, 3, k, k);
      push_td(9, 4'b0010); push_td(13, 4'b0001); push_td(22, 4'b0100); push_td(31, 4'b1000);
      skip_mask = 16'h00F0; start = 1'b1; cyc = 0;
      for (int c = 1; c <= 34; c++) begin
         step();
         start = 1'b0;
         ev = '0; em = '0;
         if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            j = exp_iss.pop_front();
            ev = {1'b1, 2'(j.u), 2'(j.t), 2'(j.k)};
         end
         if (exp_td.size() > 0 && exp_td[0].cyc == cyc) begin
            d = exp_td.pop_front();
            em = d.mask;
         end
         n_total++;
         if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== ev)
            $display("FAIL part_issue c%0d: got %b expected %b", cyc, {issue_valid, issue_unit, issue_tile, issue_kchunk}, ev);
         else n_pass++;
         n_total++;
         if (tile_done !== em) $display("FAIL part_tile_done c%0d: got %b expected %b", cyc, tile_done, em);
         else n_pass++;
         n_total++;
         if (done !== (cyc == done_cyc)) $display("FAIL part_done c%0d: got %b expected %b", cyc, done, cyc == done_cyc);
         else n_pass++;
      end
      n_total++;
      if ({busy, jobs_issued} !== {1'b0, 5'd12})
         $display("FAIL part_end: got busy=%0b jobs=%0d expected busy=0 jobs=12", busy, jobs_issued);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      job_t j; logic [6:0] ev; logic [3:0] em;
      do_reset();
      lat = 0;
      for (int k = 0; k < 4; k++) push_job(1 + k, 0, k, k);
      push_job(5, 1, 0, 0); push_job(6, 1, 1, 2); push_job(8, 1, 2, 3); push_job(9, 1, 3, 1);
      start = 1'b1; cyc = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         start = 1'b0;
         if (cyc == 4) unit_done = 4'b0101;
         if (cyc == 7) unit_done = 4'b1010;
         ev = '0;
         em = (cyc == 8) ? 4'b0001 : 4'b0000;
         if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            j = exp_iss.pop_front();
            ev = {1'b1, 2'(j.u), 2'(j.t), 2'(j.k)};
         end
         n_total++;
         if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== ev)
            $display("FAIL simul_issue c%0d: got %b expected %b", cyc, {issue_valid, issue_unit, issue_tile, issue_kchunk}, ev);
         else n_pass++;
         n_total++;
         if (tile_done !== em) $display("FAIL simul_tile_done c%0d: got %b expected %b", cyc, tile_done, em);
         else n_pass++;
      end
      n_total++;
      if ({busy, done, jobs_issued} !== {1'b1, 1'b0, 5'd8})
         $display("FAIL simul_end: got busy=%0b done=%0b jobs=%0d expected busy=1 done=0 jobs=8", busy, done, jobs_issued);
      else n_pass++;
   endtask

   task automatic test_reset_robust();
      job_t j; td_t d; logic [6:0] ev; logic [3:0] em;
      do_reset();
      lat = 3; done_cyc = 28;
      for (int n = 0; n < 6; n++) push_job(n + 1, n / 4, n % 4, n % 4);
      for (int n = 0; n < 16; n++) push_job(n + 8, n / 4, n % 4, n % 4);
      for (int t = 0; t < 4; t++) push_td(15 + 4 * t, 4'(1 << t));
      start = 1'b1; cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         step();
         start = 1'b0;
         if (cyc == 3) begin start = 1'b1; skip_mask = '1; end
         if (cyc == 6) rst = 1'b1;
         if (cyc == 7) begin
            rst = 1'b0; start = 1'b1; skip_mask = '0;
            n_total++;
            if ({busy, done, tile_done, jobs_issued} !== 11'd0)
               $display("FAIL robust_after_rst: got busy=%0b done=%0b td=%b jobs=%0d expected all 0", busy, done, tile_done, jobs_issued);
            else n_pass++;
         end
         ev = '0; em = '0;
         if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            j = exp_iss.pop_front();
            ev = {1'b1, 2'(j.u), 2'(j.t), 2'(j.k)};
         end
         if (exp_td.size() > 0 && exp_td[0].cyc == cyc) begin
            d = exp_td.pop_front();
            em = d.mask;
         end
         n_total++;
         if ({issue_valid, issue_unit, issue_tile, issue_kchunk} !== ev)
            $display("FAIL robust_issue c%0d: got %b expected %b", cyc, {issue_valid, issue_unit, issue_tile, issue_kchunk}, ev);
         else n_pass++;
         n_total++;
         if (tile_done !== em) $display("FAIL robust_tile_done c%0d: got %b expected %b", cyc, tile_done, em);
         else n_pass++;
         n_total++;
         if (done !== (cyc == done_cyc)) $display("FAIL robust_done c%0d: got %b expected %b", cyc, done, cyc == done_cyc);
         else n_pass++;
      end
      n_total++;
      if ({busy, jobs_issued} !== {1'b0, 5'd16})
         $display("FAIL robust_end: got busy=%0b jobs=%0d expected busy=0 jobs=16", busy, jobs_issued);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_unit_fill();
      test_full_sweep();
      test_all_skipped();
      test_partial_skip();
      test_simultaneous();
      test_reset_robust();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pim_job_scheduler.md
# pim_job_scheduler

Dispatches the sub-chunk jobs of one blocked matrix multiply onto a shared pool of PIM units. Each job is (output tile, k-chunk) and is issued to any free unit in round-robin order. Jobs whose product is known to be zero are skipped without using a unit. The block tracks outstanding work per tile, pulses `tile_done` when a tile's accumulation is complete and pulses `done` when the whole sweep has drained. It sits between the top-level matrix-multiply FSM and the PIM unit array; operand muxing and accumulation stay downstream.

## Interface
Parameters:
- `NUM_UNITS`, default 4: number of PIM units in the pool.
- `NUM_TILES`, default 4: number of output tiles (chunk rows × chunk cols).
- `NUM_KCHUNKS`, default 4: number of capacity-sized k-slices per tile.

Ports:
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: begins a sweep; sampled only in IDLE.
- `skip_mask` input, NUM_TILES*NUM_KCHUNKS bits: bit t*NUM_KCHUNKS+k = 1 means job (t,k) yields zero; latched on accepted `start`.
- `unit_done` input, NUM_UNITS bits: one-cycle pulse per unit when its job completes; several bits may be high at once.
- `issue_valid` output, 1 bit: a job is dispatched this cycle.
- `issue_unit` output, clog2(NUM_UNITS) bits: target unit.
- `issue_tile` output, clog2(NUM_TILES) bits: tile index of the job.
- `issue_kchunk` output, clog2(NUM_KCHUNKS) bits: k-slice index of the job.
- `tile_done` output, NUM_TILES bits: one-cycle pulse per tile when all of its non-skipped jobs have completed.
- `busy` output, 1 bit: state ≠ IDLE.
- `done` output, 1 bit: one-cycle pulse at sweep end.
- `jobs_issued` output, clog2(NUM_TILES*NUM_KCHUNKS+1) bits: jobs dispatched in the current or last sweep.

## Operation
States:
- IDLE: `start` → latch `skip_mask`, cursor=0, clear `jobs_issued`, `evaluated`, `fired`, `outstanding` → DISPATCH.
- DISPATCH: one job is evaluated per cycle. Cursor order is tile-major: j = t*NUM_KCHUNKS+k, ascending.
  - Skipped job: advance cursor; no issue.
  - Non-skipped job with a free unit: issue it, advance cursor, `jobs_issued`++.
  - Non-skipped job with no free unit: stall with the cursor held.
  - After the final job (j = NUM_TILES*NUM_KCHUNKS-1) is evaluated → DRAIN.
- DRAIN: when the registered busy mask is 0 → DONE.
- DONE: `done`=1 for this cycle → IDLE.

Unit tracking:
- Per-unit busy bit and stored tile id.
- Busy bit is set at the issue edge and cleared at the edge sampling `unit_done[u]`.
- `unit_done` on a unit that is not busy is ignored.
- A unit freed by `unit_done` in cycle c is not eligible for issue until cycle c+1. The free mask uses registered busy bits.

Arbitration:
- Grant the first free unit at or after `rr_ptr`, wrapping modulo NUM_UNITS.
- After a grant, `rr_ptr` = grant+1 (wraps to 0).
- `rr_ptr` resets to 0 on `rst` only, not per sweep.

Tile accounting:
- `outstanding[t]` has width clog2(NUM_KCHUNKS+1). It increments on issue to t and decrements on `unit_done` of a unit holding t.
- Issue and done for the same tile in the same cycle leave it unchanged.
- `evaluated[t]` is set at the edge where job (t, NUM_KCHUNKS-1) is evaluated.
- `tile_done[t]` = `evaluated[t]` & (`outstanding[t]`==0) & !`fired[t]`. `fired[t]` sets at that edge, so each tile fires exactly once per sweep.
- A fully skipped tile fires immediately after it is evaluated.

Other behaviour:
- `start` outside IDLE is ignored; `skip_mask` is not re-sampled.
- `rst` mid-sweep: return to IDLE; clear all busy, outstanding, evaluated and fired state. `unit_done` pulses after reset are ignored.

## Timing
- Reset values: `issue_valid`=0, `issue_unit`/`issue_tile`/`issue_kchunk`=0, `tile_done`=0, `busy`=0, `done`=0, `jobs_issued`=0.
- `issue_*`, `tile_done` and `done` are combinational from registered state only, with no input-to-output paths. `issue_*` are 0 when `issue_valid`=0.
- `start` sampled at the end of cycle 0 → state is DISPATCH and the first job is evaluated in cycle 1.
- Peak rate: 1 issue per cycle.
- The last `unit_done` sampled in cycle c (cursor already exhausted) → DRAIN sees idle in c+1 → `done` high in c+2.
- A unit is expected to pulse `unit_done` no earlier than one cycle after its issue.

## Test plan
- **Unit fill.** Defaults, `skip_mask`=0, `start` in cycle 0, no `unit_done` → issues in cycles 1–4 to units 0,1,2,3 with (t,k) = (0,0),(0,1),(0,2),(0,3); stall from cycle 5 with `issue_valid`=0.
- **Full sweep, fixed latency.** Each unit pulses `unit_done` 3 cycles after issue → all 16 jobs issued; `tile_done` bits pulse once each in order 0,1,2,3; `jobs_issued`=16; single `done` pulse 2 cycles after the last `unit_done`.
- **All skipped.** `skip_mask`=all ones → no issues; `tile_done[0]` in cycle 5, `[1]` in 9, `[2]` in 13, `[3]` in 17; `done` in cycle 18; `jobs_issued`=0.
- **Partial skip.** `skip_mask`=16'h00F0 (tile 1 fully skipped) → 12 issues; `tile_done[1]` fires while tile 0 jobs are still outstanding; no job with t=1 is ever issued.
- **Simultaneous events.** `unit_done` on units 0 and 2 in the same cycle as an issue to tile 0 → outstanding counts stay correct; freed units are not granted in that cycle; round robin resumes at `rr_ptr`.
- **Reset and robustness.** Assert `rst` in cycle 6 of a sweep, then `start` again → all outputs return to reset values, stale `unit_done` is ignored, and the new sweep issues first to unit 0. Also check a `start` pulse during DISPATCH is ignored.
